// File: rtl/tcdm_mem_pkg.sv
// Shared types, default geometry and row-index helper for the TCDM memory bank.
package tcdm_mem_pkg;

    localparam int unsigned TCDM_DATA_WIDTH = 64;
    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_NUM_ROWS   = 1024;

    localparam int unsigned OFFS = $clog2(TCDM_DATA_WIDTH / 8);
    localparam int unsigned IDXW = $clog2(TCDM_NUM_ROWS);

    typedef struct packed {
        logic [TCDM_ADDR_WIDTH-1:0]   add;
        logic                         wen;
        logic [TCDM_DATA_WIDTH/8-1:0] be;
        logic [TCDM_DATA_WIDTH-1:0]   wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic                       r_valid;
        logic [TCDM_DATA_WIDTH-1:0] r_rdata;
        logic                       r_opc;
    } tcdm_rsp_t;

    // Word row selected by a byte address: drop the byte offset, keep idxw bits.
    function automatic int unsigned row_idx(input logic [63:0] add,
                                            input int unsigned offs,
                                            input int unsigned idxw);
        logic [63:0] mask;
        mask = (64'd1 << idxw) - 64'd1;
        return 32'((add >> offs) & mask);
    endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; pointer moves past the last winner.
module tcdm_rr_arbiter #(
    parameter  int unsigned NB_PORTS = 2,
    localparam int unsigned PW       = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [NB_PORTS-1:0] req,
    output logic [NB_PORTS-1:0] gnt,
    output logic [PW-1:0]       idx,
    output logic                valid
);

    logic [PW-1:0] ptr;
    int unsigned   p;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        p     = 0;
        for (int unsigned i = 0; i < NB_PORTS; i++) begin
            p = (32'(ptr) + i) % NB_PORTS;
            if (!valid && req[p]) begin
                gnt[p] = 1'b1;
                idx    = PW'(p);
                valid  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            ptr <= '0;
        end else if (valid) begin
            ptr <= (idx == PW'(NB_PORTS - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tcdm_mem_bank.sv
// Single-ported TCDM bank: RR-arbitrated access, fixed-latency response per port.
module tcdm_mem_bank
    import tcdm_mem_pkg::*;
#(
    parameter  int unsigned NB_PORTS     = 2,
    parameter  int unsigned DATA_WIDTH   = TCDM_DATA_WIDTH,
    parameter  int unsigned ADDR_WIDTH   = TCDM_ADDR_WIDTH,
    parameter  int unsigned NUM_ROWS     = TCDM_NUM_ROWS,
    parameter  int unsigned READ_LATENCY = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_n,
    input  logic [NB_PORTS-1:0]                 req_i,
    input  logic [NB_PORTS*ADDR_WIDTH-1:0]      add_i,
    input  logic [NB_PORTS-1:0]                 wen_i,
    input  logic [NB_PORTS*DATA_WIDTH/8-1:0]    be_i,
    input  logic [NB_PORTS*DATA_WIDTH-1:0]      wdata_i,
    output logic [NB_PORTS-1:0]                 gnt_o,
    output logic [NB_PORTS-1:0]                 r_valid_o,
    output logic [NB_PORTS*DATA_WIDTH-1:0]      r_rdata_o,
    output logic [NB_PORTS-1:0]                 r_opc_o
);

    localparam int unsigned BW         = DATA_WIDTH / 8;
    localparam int unsigned BANK_OFFS  = $clog2(BW);
    localparam int unsigned BANK_IDXW  = $clog2(NUM_ROWS);
    localparam int unsigned PW         = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam logic [63:0] BANK_BYTES = 64'(NUM_ROWS) * 64'(BW);

    typedef struct packed {
        logic                  valid;
        logic [PW-1:0]         idx;
        logic                  opc;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_stage_t;

    logic [NB_PORTS-1:0]   arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  take;
    logic [ADDR_WIDTH-1:0] sel_add;
    logic                  sel_wen;
    logic [BW-1:0]         sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BANK_IDXW-1:0]  row;
    logic                  oor;
    logic [DATA_WIDTH-1:0] mem [NUM_ROWS];
    rsp_stage_t            s1;
    rsp_stage_t            rsp;

    tcdm_rr_arbiter #(
        .NB_PORTS (NB_PORTS)
    ) i_arb (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .req   (req_i),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Grants are suppressed while reset is held so nothing is issued mid-reset.
    assign take  = arb_valid & ~rst_n;
    assign gnt_o = take ? arb_gnt : '0;

    assign sel_add   = add_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wen   = wen_i[arb_idx];
    assign sel_be    = be_i[int'(arb_idx)*BW +: BW];
    assign sel_wdata = wdata_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign row       = BANK_IDXW'(row_idx(64'(sel_add), BANK_OFFS, BANK_IDXW));
    assign oor       = 64'(sel_add) >= BANK_BYTES;

    always_ff @(posedge clk_i) begin
        if (take && !sel_wen && !oor) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (sel_be[b]) mem[row][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            s1 <= '0;
        end else begin
            s1.valid <= take;
            s1.idx   <= arb_idx;
            s1.opc   <= take & oor;
            s1.rdata <= (take && sel_wen && !oor) ? mem[row] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        rsp_stage_t s2;
        always_ff @(posedge clk_i or posedge rst_n) begin
            if (rst_n) s2 <= '0;
            else       s2 <= s1;
        end
        assign rsp = s2;
    end else begin : g_lat1
        assign rsp = s1;
    end

    always_comb begin
        r_valid_o = '0;
        r_rdata_o = '0;
        r_opc_o   = '0;
        if (rsp.valid) begin
            r_valid_o[rsp.idx]                                = 1'b1;
            r_opc_o[rsp.idx]                                  = rsp.opc;
            r_rdata_o[int'(rsp.idx)*DATA_WIDTH +: DATA_WIDTH] = rsp.rdata;
        end
    end

endmodule

// File: tb/tb_tcdm_mem_bank.sv
// Directed per-cycle vector bench for tcdm_mem_bank at read latency 1 and 2.
module tb_tcdm_mem_bank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   d1_req, d1_wen, d1_gnt, d1_rv, d1_opc;
    logic [63:0]  d1_add;
    logic [15:0]  d1_be;
    logic [127:0] d1_wd, d1_rd;
    logic [1:0]   d2_req, d2_wen, d2_gnt, d2_rv, d2_opc;
    logic [63:0]  d2_add;
    logic [15:0]  d2_be;
    logic [127:0] d2_wd, d2_rd;

    tcdm_mem_bank dut1 (
        .clk_i(clk), .rst_n(rst_n), .req_i(d1_req), .add_i(d1_add), .wen_i(d1_wen),
        .be_i(d1_be), .wdata_i(d1_wd), .gnt_o(d1_gnt), .r_valid_o(d1_rv),
        .r_rdata_o(d1_rd), .r_opc_o(d1_opc)
    );

    tcdm_mem_bank #(.READ_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_n(rst_n), .req_i(d2_req), .add_i(d2_add), .wen_i(d2_wen),
        .be_i(d2_be), .wdata_i(d2_wd), .gnt_o(d2_gnt), .r_valid_o(d2_rv),
        .r_rdata_o(d2_rd), .r_opc_o(d2_opc)
    );

    typedef struct {
        bit          sel;
        logic [1:0]  req, wen;
        logic [31:0] add0, add1;
        logic [7:0]  be0, be1;
        logic [63:0] wd0, wd1;
        logic [1:0]  eg, erv;
        logic [63:0] erd0, erd1;
        logic [1:0]  eopc;
    } vec_t;

    vec_t vecs[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [63:0] D  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] H  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] F  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] P  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] C  = 64'hCAFE_BABE_0000_1111;
    localparam logic [63:0] A1 = 64'h0101_0101_1111_1111;
    localparam logic [63:0] A2 = 64'h0202_0202_2222_2222;
    localparam logic [63:0] A3 = 64'h0303_0303_3333_3333;

    function automatic vec_t mk(bit sel, logic [1:0] req, logic [1:0] wen,
                                logic [31:0] add0, logic [31:0] add1,
                                logic [7:0] be0, logic [7:0] be1,
                                logic [63:0] wd0, logic [63:0] wd1,
                                logic [1:0] eg, logic [1:0] erv,
                                logic [63:0] erd0, logic [63:0] erd1, logic [1:0] eopc);
        vec_t v;
        v.sel = sel; v.req = req; v.wen = wen; v.add0 = add0; v.add1 = add1;
        v.be0 = be0; v.be1 = be1; v.wd0 = wd0; v.wd1 = wd1;
        v.eg = eg; v.erv = erv; v.erd0 = erd0; v.erd1 = erd1; v.eopc = eopc;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h required %h", name, id, got, exp);
        end
    endtask

    task automatic idle_all();
        d1_req = '0; d1_wen = '0; d1_add = '0; d1_be = '0; d1_wd = '0;
        d2_req = '0; d2_wen = '0; d2_add = '0; d2_be = '0; d2_wd = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        if (v.sel) begin
            d2_req = v.req; d2_wen = v.wen; d2_add = {v.add1, v.add0};
            d2_be = {v.be1, v.be0}; d2_wd = {v.wd1, v.wd0};
        end else begin
            d1_req = v.req; d1_wen = v.wen; d1_add = {v.add1, v.add0};
            d1_be = {v.be1, v.be0}; d1_wd = {v.wd1, v.wd0};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Port-level vectors for the latency-1 bank, then the latency-2 bank.
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h28, 0, 8'hFF, 0, D, 0, 2'b01, 2'b00, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h28, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h28, 0, 8'hFF, 0, 0, 0, 2'b01, 2'b01, D, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h28, 0, 8'h0F, 0, F, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h28, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b10, 2'b11, 0, 32'h28, 0, 0, 0, 0, 2'b10, 2'b01, H, 0, 2'b00));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 2'b11, 2'b01, 32'h28, 32'h30, 0, 8'hFF, 0, P,
                              2'b01, 2'b10, 0, (i == 0) ? H : 64'h0, 2'b00));
            vecs.push_back(mk(0, 2'b11, 2'b01, 32'h28, 32'h30, 0, 8'hFF, 0, P,
                              2'b10, 2'b01, H, 0, 2'b00));
        end
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h30, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h2000, 0, 0, 0, 0, 0, 2'b01, 2'b01, P, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h2028, 0, 8'hFF, 0, F, 0, 2'b01, 2'b01, 0, 0, 2'b01));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h28, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b01));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, H, 0, 2'b00));
        vecs.push_back(mk(0, 2'b10, 2'b10, 0, 32'h2000, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h1FF8, 0, 8'hFF, 0, C, 0, 2'b01, 2'b00, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h1FF8, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, C, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 32'h08, 0, 8'hFF, 0, A1, 0, 2'b01, 2'b00, 0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 32'h10, 0, 8'hFF, 0, A2, 0, 2'b01, 2'b00, 0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 32'h18, 0, 8'hFF, 0, A3, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 32'h08, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 32'h10, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 32'h18, 0, 0, 0, 0, 0, 2'b01, 2'b01, A1, 0, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, A2, 0, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, A3, 0, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00));

        // Reset sequence with a read in flight on port 0.
        idle_all();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        d1_req = 2'b11; d1_wen = 2'b11; d1_add = {32'h2000, 32'h2000};
        @(negedge clk);
        chk("rst_first_gnt", 900, 128'(d1_gnt), 128'(2'b01));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_gnt", 901 + i, 128'(d1_gnt), 128'(0));
            chk("rst_hold_rvalid", 901 + i, 128'(d1_rv), 128'(0));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        d1_req = 2'b00;
        @(negedge clk);
        chk("rst_no_replay", 903, 128'(d1_rv), 128'(0));
        @(posedge clk); #1;
        d1_req = 2'b11;
        @(negedge clk);
        chk("rst_ptr_zero", 904, 128'(d1_gnt), 128'(2'b01));
        @(posedge clk); #1;
        d1_req = 2'b00;
        @(negedge clk);
        chk("rst_after_rvalid", 905, 128'(d1_rv), 128'(2'b01));
        chk("rst_after_opc", 905, 128'(d1_opc), 128'(2'b01));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].sel) begin
                chk("gnt", i, 128'(d2_gnt), 128'(vecs[i].eg));
                chk("rvalid", i, 128'(d2_rv), 128'(vecs[i].erv));
                chk("rdata", i, d2_rd, {vecs[i].erd1, vecs[i].erd0});
                chk("opc", i, 128'(d2_opc), 128'(vecs[i].eopc));
            end else begin
                chk("gnt", i, 128'(d1_gnt), 128'(vecs[i].eg));
                chk("rvalid", i, 128'(d1_rv), 128'(vecs[i].erv));
                chk("rdata", i, d1_rd, {vecs[i].erd1, vecs[i].erd0});
                chk("opc", i, 128'(d1_opc), 128'(vecs[i].eopc));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
